// File: rtl/cub_mult_share_if.sv
// rtl/cub_mult_share_if.sv - activation and ALU request/response signals for cub_mult_share
interface cub_mult_share_if #(
    parameter int MCAND_W = 33,
    parameter int MPLR_W  = 17,
    parameter int PDT_W   = MCAND_W + MPLR_W
);
    logic                      prelu_mult_en;
    logic signed [MCAND_W-1:0] prelu_mult_multiplicand;
    logic signed [MPLR_W-1:0]  prelu_mult_multiplier;
    logic signed [PDT_W-1:0]   prelu_mult_product;
    logic                      prelu_mult_pdt_valid;

    logic                      alu_mul_req_valid;
    logic                      alu_mul_req_ready;
    logic signed [MCAND_W-1:0] alu_mul_a;
    logic signed [MPLR_W-1:0]  alu_mul_b;
    logic                      alu_mul_rsp_valid;
    logic                      alu_mul_rsp_ready;
    logic signed [PDT_W-1:0]   alu_mul_rsp_data;
    logic [15:0]               alu_mul_stall_cnt;

    modport master (
        output prelu_mult_en, prelu_mult_multiplicand, prelu_mult_multiplier,
        input  prelu_mult_product, prelu_mult_pdt_valid,
        output alu_mul_req_valid, alu_mul_a, alu_mul_b, alu_mul_rsp_ready,
        input  alu_mul_req_ready, alu_mul_rsp_valid, alu_mul_rsp_data, alu_mul_stall_cnt
    );

    modport slave (
        input  prelu_mult_en, prelu_mult_multiplicand, prelu_mult_multiplier,
        output prelu_mult_product, prelu_mult_pdt_valid,
        input  alu_mul_req_valid, alu_mul_a, alu_mul_b, alu_mul_rsp_ready,
        output alu_mul_req_ready, alu_mul_rsp_valid, alu_mul_rsp_data, alu_mul_stall_cnt
    );
endinterface

// File: rtl/cub_mult_share.sv
// rtl/cub_mult_share.sv - shared signed multiplier, activation first, ALU on idle cycles
// Optional stall counter enabled by defining CUB_MULT_PERF_CNT_EN.
module cub_mult_share #(
    parameter int MCAND_W = 33,
    parameter int MPLR_W  = 17,
    parameter int PDT_W   = MCAND_W + MPLR_W
) (
    input  logic             clk,
    input  logic             rst,
    cub_mult_share_if.slave  bus
);
    logic signed [PDT_W-1:0]   pdt_q, pdt_d;
    logic                      pdt_valid_q, pdt_valid_d;
    logic                      inflight_q, inflight_d;
    logic [PDT_W-1:0]          fifo_mem_q [2];
    logic [PDT_W-1:0]          fifo_mem_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                fifo_cnt_q, fifo_cnt_d;

    logic [1:0]                occ;
    logic                      alu_grant;
    logic                      push;
    logic                      pop;
    logic                      rsp_valid;
    logic signed [MCAND_W-1:0] op_a;
    logic signed [MPLR_W-1:0]  op_b;

    // Credits cover both buffered results and the product still in pdt_q.
    assign occ       = fifo_cnt_q + {1'b0, inflight_q};
    assign alu_grant = bus.alu_mul_req_valid & ~bus.prelu_mult_en & (occ < 2'd2);
    assign rsp_valid = (fifo_cnt_q != 2'd0);
    assign push      = inflight_q;
    assign pop       = rsp_valid & bus.alu_mul_rsp_ready;

    always_comb begin
        op_a        = bus.alu_mul_a;
        op_b        = bus.alu_mul_b;
        pdt_d       = pdt_q;
        pdt_valid_d = bus.prelu_mult_en;
        inflight_d  = alu_grant;
        if (bus.prelu_mult_en) begin
            op_a = bus.prelu_mult_multiplicand;
            op_b = bus.prelu_mult_multiplier;
        end
        if (bus.prelu_mult_en || alu_grant) begin
            pdt_d = PDT_W'(op_a) * PDT_W'(op_b);
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = pdt_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pdt_q       <= '0;
            pdt_valid_q <= 1'b0;
            inflight_q  <= 1'b0;
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            pdt_q       <= pdt_d;
            pdt_valid_q <= pdt_valid_d;
            inflight_q  <= inflight_d;
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign bus.prelu_mult_product   = pdt_q;
    assign bus.prelu_mult_pdt_valid = pdt_valid_q;
    assign bus.alu_mul_req_ready    = alu_grant;
    assign bus.alu_mul_rsp_valid    = rsp_valid;
    assign bus.alu_mul_rsp_data     = fifo_mem_q[rd_ptr_q];

`ifdef CUB_MULT_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.alu_mul_req_valid && !alu_grant && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.alu_mul_stall_cnt = stall_cnt_q;
`else
    assign bus.alu_mul_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_cub_mult_share.sv
// tb/tb_cub_mult_share.sv - directed scoreboard bench for cub_mult_share
module tb_cub_mult_share;
    logic clk;
    logic rst;

    cub_mult_share_if bus ();

    cub_mult_share dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [49:0] act_q[$];
    logic signed [49:0] alu_q[$];
    logic               exp_pv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge, then advance past the next rising edge.
    task automatic tick();
        logic signed [49:0] e;
        logic               pv_next;
        @(negedge clk);
        chk("pdt_valid", 64'(bus.prelu_mult_pdt_valid), 64'(exp_pv));
        if (exp_pv) begin
            chk("act_q_nonempty", 64'(act_q.size() != 0), 64'd1);
            if (act_q.size() != 0) begin
                e = act_q.pop_front();
                chk("act_product", bus.prelu_mult_product, e);
            end
        end
        if (bus.alu_mul_rsp_valid === 1'b1 && bus.alu_mul_rsp_ready === 1'b1) begin
            chk("alu_rsp_expected", 64'(alu_q.size() != 0), 64'd1);
            if (alu_q.size() != 0) begin
                e = alu_q.pop_front();
                chk("alu_rsp_data", bus.alu_mul_rsp_data, e);
            end
        end
        pv_next = rst ? 1'b0 : bus.prelu_mult_en;
        @(posedge clk);
        exp_pv = pv_next;
        if (rst) begin
            act_q.delete();
            alu_q.delete();
        end
        #1;
    endtask

    initial begin
        exp_pv                      = 1'b0;
        rst                         = 1'b1;
        bus.prelu_mult_en           = 1'b0;
        bus.prelu_mult_multiplicand = '0;
        bus.prelu_mult_multiplier   = '0;
        bus.alu_mul_req_valid       = 1'b0;
        bus.alu_mul_a               = '0;
        bus.alu_mul_b               = '0;
        bus.alu_mul_rsp_ready       = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_product", bus.prelu_mult_product, 50'sd0);
        chk("rst_pdt_valid", 64'(bus.prelu_mult_pdt_valid), 64'd0);
        chk("rst_rsp_valid", 64'(bus.alu_mul_rsp_valid), 64'd0);
        chk("rst_rsp_data", bus.alu_mul_rsp_data, 50'sd0);
        chk("rst_stall_cnt", 64'(bus.alu_mul_stall_cnt), 64'd0);
        rst = 1'b0;

        // 1: activation only, negative multiplicand
        bus.prelu_mult_en           = 1'b1;
        bus.prelu_mult_multiplicand = 33'h1_0000_0003;
        bus.prelu_mult_multiplier   = 17'd5;
        act_q.push_back(-50'sd21474836465);
        tick();
        bus.prelu_mult_en = 1'b0;
        tick();
        tick();
        chk("t1_rsp_valid", 64'(bus.alu_mul_rsp_valid), 64'd0);

        // 2: ALU only, two-cycle latency, single beat
        bus.alu_mul_req_valid = 1'b1;
        bus.alu_mul_a         = -33'sd7;
        bus.alu_mul_b         = -17'sd3;
        #1;
        chk("t2_req_ready", 64'(bus.alu_mul_req_ready), 64'd1);
        alu_q.push_back(50'sd21);
        tick();
        bus.alu_mul_req_valid = 1'b0;
        #1;
        chk("t2_rsp_valid_c1", 64'(bus.alu_mul_rsp_valid), 64'd0);
        tick();
        chk("t2_rsp_valid_c2", 64'(bus.alu_mul_rsp_valid), 64'd1);
        chk("t2_rsp_data", bus.alu_mul_rsp_data, 50'sd21);
        tick();
        chk("t2_one_beat", 64'(bus.alu_mul_rsp_valid), 64'd0);

        // 3: collision, activation wins, ALU granted next cycle
        bus.prelu_mult_en           = 1'b1;
        bus.prelu_mult_multiplicand = 33'sd3;
        bus.prelu_mult_multiplier   = 17'sd4;
        bus.alu_mul_req_valid       = 1'b1;
        bus.alu_mul_a               = 33'sd10;
        bus.alu_mul_b               = 17'sd11;
        act_q.push_back(50'sd12);
        #1;
        chk("t3_ready_blocked", 64'(bus.alu_mul_req_ready), 64'd0);
        tick();
        bus.prelu_mult_en = 1'b0;
        #1;
        chk("t3_ready_granted", 64'(bus.alu_mul_req_ready), 64'd1);
        alu_q.push_back(50'sd110);
        tick();
        bus.alu_mul_req_valid = 1'b0;
        tick();
        tick();
        tick();

        // 4: backpressure, credit limit, in-order drain
        bus.alu_mul_rsp_ready = 1'b0;
        bus.alu_mul_req_valid = 1'b1;
        bus.alu_mul_a = 33'sd2; bus.alu_mul_b = 17'sd3;
        #1;
        chk("t4_req0_ready", 64'(bus.alu_mul_req_ready), 64'd1);
        alu_q.push_back(50'sd6);
        tick();
        bus.alu_mul_a = 33'sd4; bus.alu_mul_b = 17'sd5;
        #1;
        chk("t4_req1_ready", 64'(bus.alu_mul_req_ready), 64'd1);
        alu_q.push_back(50'sd20);
        tick();
        bus.alu_mul_a = 33'sd6; bus.alu_mul_b = 17'sd7;
        #1;
        chk("t4_credit_block", 64'(bus.alu_mul_req_ready), 64'd0);
        tick();
        chk("t4_full_block", 64'(bus.alu_mul_req_ready), 64'd0);
        tick();
        bus.alu_mul_rsp_ready = 1'b1;
        #1;
        chk("t4_pop_cycle_block", 64'(bus.alu_mul_req_ready), 64'd0);
        tick();
        chk("t4_req2_ready", 64'(bus.alu_mul_req_ready), 64'd1);
        alu_q.push_back(50'sd42);
        tick();
        bus.alu_mul_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_drained", 64'(alu_q.size()), 64'd0);

        // 5: reset while an ALU op is in flight
        bus.alu_mul_req_valid = 1'b1;
        bus.alu_mul_a = 33'sd5; bus.alu_mul_b = 17'sd5;
        #1;
        chk("t5_ready", 64'(bus.alu_mul_req_ready), 64'd1);
        tick();
        bus.alu_mul_req_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("t5_rsp_valid", 64'(bus.alu_mul_rsp_valid), 64'd0);
        chk("t5_product", bus.prelu_mult_product, 50'sd0);
        chk("t5_rsp_data", bus.alu_mul_rsp_data, 50'sd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_no_stale", 64'(bus.alu_mul_rsp_valid), 64'd0);
        chk("t5_stall_clear", 64'(bus.alu_mul_stall_cnt), 64'd0);

        // 6: ALU starved by back-to-back activation
        bus.prelu_mult_en           = 1'b1;
        bus.prelu_mult_multiplicand = 33'sd1;
        bus.prelu_mult_multiplier   = -17'sd9;
        bus.alu_mul_req_valid       = 1'b1;
        bus.alu_mul_a = 33'sd2; bus.alu_mul_b = 17'sd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t6_starved", 64'(bus.alu_mul_req_ready), 64'd0);
            act_q.push_back(-50'sd9);
            tick();
        end
        bus.prelu_mult_en     = 1'b0;
        bus.alu_mul_req_valid = 1'b0;
        #1;
`ifdef CUB_MULT_PERF_CNT_EN
        chk("t6_stall_cnt", 64'(bus.alu_mul_stall_cnt), 64'd10);
`else
        chk("t6_stall_cnt", 64'(bus.alu_mul_stall_cnt), 64'd0);
`endif
        tick();
        tick();
        chk("end_act_q_empty", 64'(act_q.size()), 64'd0);
        chk("end_alu_q_empty", 64'(alu_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
